sodor_mem_router_nway: RTL and testbench

- Parametrised N-target memory request router between a Sodor core memory port and NUM_TGT downstream ports (e.g. scratchpad, master bus, MMIO).
- Decodes each request address against per-target base/mask regions and forwards the request with a ready/valid handshake.
- Records the issuing target in an in-order tracking FIFO, so each response is steered back by transaction order instead of by a separately supplied response address.

---
 rtl/sodor_router_pkg.sv | 23 ++
 rtl/sodor_router_id_fifo.sv | 59 +++++
 rtl/sodor_mem_router_nway.sv | 150 +++++++++++++++
 tb/tb_sodor_mem_router_nway.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sodor_router_pkg.sv
// Shared types and constants for the Sodor N-way memory router.
package sodor_router_pkg;

  typedef logic [1:0] tgt_id_t;

  localparam logic FCN_X     = 1'b0;
  localparam logic FCN_LOAD  = 1'b0;
  localparam logic FCN_STORE = 1'b1;

  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_D  = 3'd4;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;
  localparam logic [2:0] MT_WU = 3'd7;

  // Two-target map: target 1 is the scratchpad window, target 0 takes everything else.
  localparam logic [63:0] DEF_REGION_BASE = {32'h8000_0000, 32'h0000_0000};
  localparam logic [63:0] DEF_REGION_MASK = {32'hFFFC_0000, 32'h0000_0000};

endpackage

// File: rtl/sodor_router_id_fifo.sv
// In-order tracking FIFO of target ids; a push is accepted while full if a pop
// happens in the same cycle.
module sodor_router_id_fifo
  import sodor_router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  tgt_id_t                  i_din,
  input  logic                     i_pop,
  output tgt_id_t                  o_head,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  tgt_id_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sodor_mem_router_nway.sv
// N-target request router with in-order response steering via a tracking FIFO.
// Optional per-target request counters under macro SODOR_ROUTER_PERF_EN.
module sodor_mem_router_nway
  import sodor_router_pkg::*;
#(
  parameter int                        NUM_TGT     = 2,
  parameter int                        ADDR_W      = 32,
  parameter int                        DATA_W      = 32,
  parameter int                        MAX_OUTST   = 4,
  parameter logic [NUM_TGT*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_TGT*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter int                        DEFAULT_TGT = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        core_req_valid,
  output logic                        core_req_ready,
  input  logic [ADDR_W-1:0]           core_req_addr,
  input  logic [DATA_W-1:0]           core_req_data,
  input  logic                        core_req_fcn,
  input  logic [2:0]                  core_req_typ,
  output logic                        core_resp_valid,
  output logic [DATA_W-1:0]           core_resp_data,
  output logic [NUM_TGT-1:0]          tgt_req_valid,
  input  logic [NUM_TGT-1:0]          tgt_req_ready,
  output logic [ADDR_W-1:0]           tgt_req_addr,
  output logic [DATA_W-1:0]           tgt_req_data,
  output logic                        tgt_req_fcn,
  output logic [2:0]                  tgt_req_typ,
  input  logic [NUM_TGT-1:0]          tgt_resp_valid,
  input  logic [NUM_TGT*DATA_W-1:0]   tgt_resp_data,
  output logic                        busy,
  output logic                        err_stray
`ifdef SODOR_ROUTER_PERF_EN
  ,
  output logic [NUM_TGT*32-1:0]       perf_req_cnt,
  input  logic                        perf_clr
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  tgt_id_t          w_sel;
  tgt_id_t          w_head;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_full_eff;
  logic             w_sel_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_head_valid;
  logic             w_stray;
  logic             r_err_stray;

  // An all-zero mask marks a catch-all region; it is reached only through DEFAULT_TGT,
  // so a specific window at a higher index is not shadowed by it.
  always_comb begin
    w_sel = tgt_id_t'(DEFAULT_TGT);
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((REGION_MASK[i*ADDR_W +: ADDR_W] != '0) &&
          ((core_req_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W])) begin
        w_sel = tgt_id_t'(i);
      end
    end
  end

  assign w_full_eff = (w_count == CNT_W'(MAX_OUTST)) & ~w_pop;

  always_comb begin
    tgt_req_valid = '0;
    w_sel_ready   = 1'b0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (w_sel == tgt_id_t'(i)) begin
        tgt_req_valid[i] = core_req_valid & ~w_full_eff;
        w_sel_ready      = tgt_req_ready[i];
      end
    end
  end

  assign core_req_ready = w_sel_ready & ~w_full_eff;
  assign w_push         = core_req_valid & core_req_ready;

  assign tgt_req_addr = core_req_addr;
  assign tgt_req_data = core_req_data;
  assign tgt_req_fcn  = core_req_fcn;
  assign tgt_req_typ  = core_req_typ;

  always_comb begin
    w_head_valid   = 1'b0;
    core_resp_data = '0;
    w_stray        = 1'b0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (w_head == tgt_id_t'(i)) begin
        w_head_valid   = tgt_resp_valid[i];
        core_resp_data = tgt_resp_data[i*DATA_W +: DATA_W];
      end else if (tgt_resp_valid[i]) begin
        w_stray = 1'b1;
      end
    end
    if (w_empty) begin
      w_stray = |tgt_resp_valid;
    end
  end

  assign core_resp_valid = ~w_empty & w_head_valid;
  assign w_pop           = core_resp_valid;

  sodor_router_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_sel),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_stray <= 1'b0;
    end else if (w_stray) begin
      r_err_stray <= 1'b1;
    end
  end

  assign err_stray = r_err_stray;
  assign busy      = (w_count != '0);

`ifdef SODOR_ROUTER_PERF_EN
  logic [NUM_TGT*32-1:0] r_perf_cnt;

  always_ff @(posedge clock) begin
    if (reset || perf_clr) begin
      r_perf_cnt <= '0;
    end else if (w_push) begin
      for (int i = 0; i < NUM_TGT; i++) begin
        if (w_sel == tgt_id_t'(i)) begin
          r_perf_cnt[i*32 +: 32] <= r_perf_cnt[i*32 +: 32] + 32'd1;
        end
      end
    end
  end

  assign perf_req_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_sodor_mem_router_nway.sv
// Scoreboard bench for sodor_mem_router_nway (default 2-target map).
module tb_sodor_mem_router_nway;
  import sodor_router_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_req_valid;
  logic        core_req_ready;
  logic [31:0] core_req_addr;
  logic [31:0] core_req_data;
  logic        core_req_fcn;
  logic [2:0]  core_req_typ;
  logic        core_resp_valid;
  logic [31:0] core_resp_data;
  logic [1:0]  tgt_req_valid;
  logic [1:0]  tgt_req_ready;
  logic [31:0] tgt_req_addr;
  logic [31:0] tgt_req_data;
  logic        tgt_req_fcn;
  logic [2:0]  tgt_req_typ;
  logic [1:0]  tgt_resp_valid;
  logic [63:0] tgt_resp_data;
  logic        busy;
  logic        err_stray;
`ifdef SODOR_ROUTER_PERF_EN
  logic [63:0] perf_req_cnt;
  logic        perf_clr;
`endif

  int n_total = 0;
  int n_pass  = 0;

  int          q_tgt[$];
  logic [31:0] q_exp[$];

  always #5 clock = ~clock;

  sodor_mem_router_nway dut (
    .clock           (clock),
    .reset           (reset),
    .core_req_valid  (core_req_valid),
    .core_req_ready  (core_req_ready),
    .core_req_addr   (core_req_addr),
    .core_req_data   (core_req_data),
    .core_req_fcn    (core_req_fcn),
    .core_req_typ    (core_req_typ),
    .core_resp_valid (core_resp_valid),
    .core_resp_data  (core_resp_data),
    .tgt_req_valid   (tgt_req_valid),
    .tgt_req_ready   (tgt_req_ready),
    .tgt_req_addr    (tgt_req_addr),
    .tgt_req_data    (tgt_req_data),
    .tgt_req_fcn     (tgt_req_fcn),
    .tgt_req_typ     (tgt_req_typ),
    .tgt_resp_valid  (tgt_resp_valid),
    .tgt_resp_data   (tgt_resp_data),
    .busy            (busy),
    .err_stray       (err_stray)
`ifdef SODOR_ROUTER_PERF_EN
    ,
    .perf_req_cnt    (perf_req_cnt),
    .perf_clr        (perf_clr)
`endif
  );

  // Scoreboard: every core response must match the oldest expected data word.
  always @(negedge clock) begin
    if (!reset && core_resp_valid) begin
      n_total++;
      if (q_exp.size() == 0) begin
        $display("FAIL resp_unexpected: got valid data %h, required no response", core_resp_data);
      end else begin
        logic [31:0] exp_d;
        exp_d = q_exp.pop_front();
        if (core_resp_data !== exp_d)
          $display("FAIL resp_data: got %h, required %h", core_resp_data, exp_d);
        else
          n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic drive_req(input logic [31:0] addr);
    core_req_valid = 1'b1;
    core_req_addr  = addr;
    core_req_data  = addr ^ 32'h1234_5678;
    core_req_fcn   = addr[4] ? FCN_STORE : FCN_LOAD;
    core_req_typ   = MT_W;
  endtask

  // Drives one target response and updates the reference order model.
  task automatic drive_resp(input int t, input logic [31:0] d);
    tgt_resp_valid = 2'b00;
    tgt_resp_valid[t] = 1'b1;
    tgt_resp_data = (t == 1) ? {d, ~d} : {~d, d};
    if (q_tgt.size() > 0 && q_tgt[0] == t) begin
      void'(q_tgt.pop_front());
      q_exp.push_back(d);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && q_tgt.size() > 0; k++) begin
      drive_resp(q_tgt[0], 32'hD000_0000 + k);
      step();
    end
    tgt_resp_valid = 2'b00;
  endtask

  task automatic reset_dut();
    reset          = 1'b1;
    core_req_valid = 1'b0;
    core_req_addr  = '0;
    core_req_data  = '0;
    core_req_fcn   = FCN_X;
    core_req_typ   = MT_X;
    tgt_req_ready  = 2'b11;
    tgt_resp_valid = 2'b00;
    tgt_resp_data  = '0;
`ifdef SODOR_ROUTER_PERF_EN
    perf_clr       = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    q_tgt.delete();
    q_exp.delete();
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
    n_total++; if (err_stray !== 1'b0) $display("FAIL rst_err: got %b, required 0", err_stray); else n_pass++;
    n_total++; if (core_resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b, required 0", core_resp_valid); else n_pass++;
    n_total++; if (tgt_req_valid !== 2'b00) $display("FAIL rst_req_idle: got %b, required 00", tgt_req_valid); else n_pass++;
    drive_req(32'h0000_1000);
    #1;
    n_total++; if (tgt_req_valid !== 2'b01) $display("FAIL rst_req_follow: got %b, required 01", tgt_req_valid); else n_pass++;
    core_req_valid = 1'b0;
  endtask

  task automatic test_routing();
    step();
    drive_req(32'h8000_0010);
    #1;
    n_total++; if (tgt_req_valid !== 2'b10) $display("FAIL route_scratch: got %b, required 10", tgt_req_valid); else n_pass++;
    n_total++; if (core_req_ready !== 1'b1) $display("FAIL route_ready: got %b, required 1", core_req_ready); else n_pass++;
    n_total++; if ({tgt_req_addr, tgt_req_data, tgt_req_fcn, tgt_req_typ} !== {32'h8000_0010, 32'h9234_5668, 1'b1, MT_W})
      $display("FAIL route_bcast: got %h %h %b %h", tgt_req_addr, tgt_req_data, tgt_req_fcn, tgt_req_typ); else n_pass++;
    q_tgt.push_back(1);
    step();
    n_total++; if (busy !== 1'b1) $display("FAIL route_busy: got %b, required 1", busy); else n_pass++;
    drive_req(32'h0000_1000);
    #1;
    n_total++; if (tgt_req_valid !== 2'b01) $display("FAIL route_master: got %b, required 01", tgt_req_valid); else n_pass++;
    q_tgt.push_back(0);
    step();
    core_req_valid = 1'b0;
    drain();
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL route_idle: got %b, required 0", busy); else n_pass++;
  endtask

  task automatic test_ordering();
    reset_dut();
    drive_req(32'h8000_0000); q_tgt.push_back(1); step();
    drive_req(32'h0000_0100); q_tgt.push_back(0); step();
    core_req_valid = 1'b0;
    drive_resp(0, 32'h0000_AAAA);
    #1;
    n_total++; if (core_resp_valid !== 1'b0) $display("FAIL order_stray_valid: got %b, required 0", core_resp_valid); else n_pass++;
    step();
    tgt_resp_valid = 2'b00;
    #1;
    n_total++; if (err_stray !== 1'b1) $display("FAIL order_err: got %b, required 1", err_stray); else n_pass++;
    reset_dut();
    #1;
    n_total++; if (err_stray !== 1'b0) $display("FAIL order_err_clr: got %b, required 0", err_stray); else n_pass++;
    drive_req(32'h8000_0000); q_tgt.push_back(1); step();
    drive_req(32'h0000_0100); q_tgt.push_back(0); step();
    core_req_valid = 1'b0;
    drive_resp(1, 32'h0000_1111); step();
    drive_resp(0, 32'h0000_2222); step();
    tgt_resp_valid = 2'b00;
    #1;
    n_total++; if (err_stray !== 1'b0) $display("FAIL order_inorder_err: got %b, required 0", err_stray); else n_pass++;
  endtask

  task automatic test_full();
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      drive_req(32'h0000_0040 * k);
      #1;
      n_total++; if (core_req_ready !== 1'b1) $display("FAIL full_fill%0d: got %b, required 1", k, core_req_ready); else n_pass++;
      q_tgt.push_back(0);
      step();
    end
    drive_req(32'h0000_0200);
    #1;
    n_total++; if (core_req_ready !== 1'b0) $display("FAIL full_ready: got %b, required 0", core_req_ready); else n_pass++;
    n_total++; if (tgt_req_valid !== 2'b00) $display("FAIL full_valid: got %b, required 00", tgt_req_valid); else n_pass++;
    step();
    drive_resp(0, 32'h0000_F00D);
    #1;
    n_total++; if (core_req_ready !== 1'b1) $display("FAIL full_pop_ready: got %b, required 1", core_req_ready); else n_pass++;
    q_tgt.push_back(0);
    step();
    core_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_resp(0, 32'hC000_0000 + k);
      step();
    end
    tgt_resp_valid = 2'b00;
    #1;
    n_total++; if (busy !== 1'b1) $display("FAIL full_count4: got busy %b after 3 drains, required 1", busy); else n_pass++;
    drain();
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL full_drained: got %b, required 0", busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    reset_dut();
    tgt_req_ready = 2'b01;
    drive_req(32'h8000_0000);
    #1;
    n_total++; if (core_req_ready !== 1'b0) $display("FAIL bp_ready: got %b, required 0", core_req_ready); else n_pass++;
    n_total++; if (tgt_req_valid !== 2'b10) $display("FAIL bp_valid: got %b, required 10", tgt_req_valid); else n_pass++;
    step();
    n_total++; if (busy !== 1'b0) $display("FAIL bp_nopush: got %b, required 0", busy); else n_pass++;
    tgt_req_ready = 2'b11;
    #1;
    n_total++; if (core_req_ready !== 1'b1) $display("FAIL bp_rise: got %b, required 1", core_req_ready); else n_pass++;
    q_tgt.push_back(1);
    step();
    core_req_valid = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL bp_push: got %b, required 1", busy); else n_pass++;
    drain();
  endtask

  task automatic test_reset_midflight();
    reset_dut();
    drive_req(32'h8000_0000); q_tgt.push_back(1); step();
    drive_req(32'h0000_0000); q_tgt.push_back(0); step();
    drive_req(32'h8000_0004); q_tgt.push_back(1); step();
    core_req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    q_tgt.delete();
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b, required 0", busy); else n_pass++;
    drive_resp(1, 32'h0000_BEEF);
    #1;
    n_total++; if (core_resp_valid !== 1'b0) $display("FAIL midrst_late: got %b, required 0", core_resp_valid); else n_pass++;
    step();
    tgt_resp_valid = 2'b00;
    #1;
    n_total++; if (err_stray !== 1'b1) $display("FAIL midrst_err: got %b, required 1", err_stray); else n_pass++;
  endtask

`ifdef SODOR_ROUTER_PERF_EN
  task automatic test_perf();
    reset_dut();
    #1;
    n_total++; if (perf_req_cnt !== 64'd0) $display("FAIL perf_rst: got %h, required 0", perf_req_cnt); else n_pass++;
    drive_req(32'h8000_0000); q_tgt.push_back(1); step();
    drive_req(32'h0000_0010); q_tgt.push_back(0); step();
    drive_req(32'h8000_0020); q_tgt.push_back(1); step();
    drive_req(32'h8000_0030); q_tgt.push_back(1); step();
    core_req_valid = 1'b0;
    #1;
    n_total++; if (perf_req_cnt !== {32'd3, 32'd1}) $display("FAIL perf_cnt: got %h, required %h", perf_req_cnt, {32'd3, 32'd1}); else n_pass++;
    drain();
    drive_req(32'h8000_0040);
    perf_clr = 1'b1;
    #1;
    n_total++; if (core_req_ready !== 1'b1) $display("FAIL perf_clr_accept: got %b, required 1", core_req_ready); else n_pass++;
    q_tgt.push_back(1);
    step();
    perf_clr = 1'b0;
    core_req_valid = 1'b0;
    #1;
    n_total++; if (perf_req_cnt !== 64'd0) $display("FAIL perf_clr: got %h, required 0", perf_req_cnt); else n_pass++;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_ordering();
    test_full();
    test_backpressure();
    test_reset_midflight();
`ifdef SODOR_ROUTER_PERF_EN
    test_perf();
`endif
    step();
    n_total++;
    if (q_exp.size() != 0) $display("FAIL resp_missing: %0d expected responses never seen, required 0", q_exp.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
